// File: rtl/rng_pkg.sv
// Shared constants and types for the range-limited LFSR random number block.
package rng_pkg;

   // Maximal-length 16-bit polynomial x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

   // Reset seed, also substituted whenever an all-zero seed is loaded.
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // Request sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_RESP = 2'd2
   } rng_state_e;

endpackage : rng_pkg

// File: rtl/lfsr_core.sv
// Fibonacci-style LFSR stepper: shift left, feedback is the parity of the
// tapped bits.  A load always wins over a step, and an all-zero load value is
// replaced by SEED so the register can never lock up at zero.
module lfsr_core
   import rng_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] w_next;
   logic             w_feedback;

   assign w_feedback = ^(r_state & TAPS);
   assign w_next     = {r_state[WIDTH-2:0], w_feedback};

   // LFSR register: reset to SEED, then load (zero-safe) over step.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SEED;
      end else if (load) begin
         r_state <= (load_val == '0) ? SEED : load_val;
      end else if (step) begin
         r_state <= w_next;
      end
   end

   assign state = r_state;

endmodule : lfsr_core

// File: rtl/lfsr_rng_range.sv
// Range-limited random number source.  A request carries an exclusive upper
// bound; the low OUT_W bits of the LFSR are offered as candidates, one per
// cycle, and rejected while they are out of range.  After MAX_TRIES
// rejections the block gives up and returns 0 flagged as a fallback result.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | ready for a request; LFSR free-runs when enable=1
//   DRAW    | one candidate tested per cycle, LFSR steps every cycle
//   RESP    | result held on rsp_* until the consumer takes it
module lfsr_rng_range
   import rng_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS),
   parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEFAULT_SEED),
   parameter int               OUT_W     = 4,
   parameter int               MAX_TRIES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OUT_W-1:0] req_lim,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [OUT_W-1:0] rsp_data,
   output logic             rsp_fallback,
   output logic [WIDTH-1:0] lfsr_state
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   // Parameter sanity: these configurations cannot produce a working block.
   if (OUT_W > WIDTH) begin : g_bad_out_w
      $error("lfsr_rng_range: OUT_W (%0d) exceeds WIDTH (%0d)", OUT_W, WIDTH);
   end
   if (MAX_TRIES < 1) begin : g_bad_tries
      $error("lfsr_rng_range: MAX_TRIES must be at least 1");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_rng_range: SEED must be nonzero");
   end

   rng_state_e       r_state;
   rng_state_e       w_next_state;

   logic [OUT_W-1:0] r_lim;
   logic [TRY_W-1:0] r_tries;
   logic [OUT_W-1:0] r_rsp_data;
   logic             r_rsp_fallback;

   logic [WIDTH-1:0] w_lfsr;
   logic [OUT_W-1:0] w_cand;
   logic             w_cand_ok;
   logic             w_last_try;

   logic             w_step;
   logic             w_capture;
   logic             w_tries_clr;
   logic             w_tries_inc;
   logic             w_latch_acc;
   logic             w_latch_fb;
   logic             w_latch_zero;

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_lfsr_core (
      .clk      (clk),
      .rst      (rst),
      .step     (w_step),
      .load     (seed_load),
      .load_val (seed_in),
      .state    (w_lfsr)
   );

   assign w_cand     = w_lfsr[OUT_W-1:0];
   assign w_cand_ok  = (w_cand < r_lim);
   // The current rejection is the MAX_TRIES-th one when MAX_TRIES-1 have
   // already been counted.
   assign w_last_try = (r_tries == TRY_W'(MAX_TRIES - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      w_next_state = r_state;
      w_step       = enable;
      w_capture    = 1'b0;
      w_tries_clr  = 1'b0;
      w_tries_inc  = 1'b0;
      w_latch_acc  = 1'b0;
      w_latch_fb   = 1'b0;
      w_latch_zero = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_capture    = 1'b1;
               w_tries_clr  = 1'b1;
               w_next_state = ST_DRAW;
            end
         end
         ST_DRAW: begin
            if (r_lim == '0) begin
               // Empty range: nothing to draw, so the LFSR is left untouched.
               w_step       = 1'b0;
               w_latch_zero = 1'b1;
               w_next_state = ST_RESP;
            end else begin
               w_step = 1'b1;
               if (w_cand_ok) begin
                  w_latch_acc  = 1'b1;
                  w_next_state = ST_RESP;
               end else begin
                  w_tries_inc = 1'b1;
                  if (w_last_try) begin
                     w_latch_fb   = 1'b1;
                     w_next_state = ST_RESP;
                  end
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Limit capture, try counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lim          <= '0;
         r_tries        <= '0;
         r_rsp_data     <= '0;
         r_rsp_fallback <= 1'b0;
      end else begin
         if (w_capture) begin
            r_lim <= req_lim;
         end
         if (w_tries_clr) begin
            r_tries <= '0;
         end else if (w_tries_inc) begin
            r_tries <= r_tries + TRY_W'(1);
         end
         if (w_latch_acc) begin
            r_rsp_data     <= w_cand;
            r_rsp_fallback <= 1'b0;
         end else if (w_latch_fb || w_latch_zero) begin
            r_rsp_data     <= '0;
            r_rsp_fallback <= w_latch_fb;
         end
      end
   end

   assign req_ready    = (r_state == ST_IDLE);
   assign rsp_valid    = (r_state == ST_RESP);
   assign rsp_data     = r_rsp_data;
   assign rsp_fallback = r_rsp_fallback;
   assign lfsr_state   = w_lfsr;

endmodule : lfsr_rng_range

// File: doc/lfsr_rng_range.md
LFSR_RNG_RANGE -- requirements
Module: lfsr_rng_range

Interface
REQ-001 Parameter WIDTH, default 16: LFSR state width in bits.
REQ-002 Parameter TAPS, default 16'hB400: feedback tap mask, XOR of masked bits (x^16+x^14+x^13+x^11+1).
REQ-003 Parameter SEED, default 16'hACE1: reset and fallback seed; SHALL be nonzero.
REQ-004 Parameter OUT_W, default 4: width of limit and result.
REQ-005 Parameter MAX_TRIES, default 8: rejection attempts before fallback, at least 1.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  free-run stepping of LFSR while idle.
REQ-009 seed_load  input  1  load seed_in into LFSR this cycle.
REQ-010 seed_in  input  WIDTH  new seed value.
REQ-011 req_valid  input  1  draw request.
REQ-012 req_ready  output  1  block accepts request.
REQ-013 req_lim  input  OUT_W  exclusive upper bound; result is 0..req_lim-1.
REQ-014 rsp_valid  output  1  result available.
REQ-015 rsp_ready  input  1  consumer accepts result.
REQ-016 rsp_data  output  OUT_W  random result.
REQ-017 rsp_fallback  output  1  result produced by fallback, not by acceptance.
REQ-018 lfsr_state  output  WIDTH  current LFSR register, for debug.

Function
REQ-019 Step: next = {state[WIDTH-2:0], ^(state & TAPS)}.
REQ-020 LFSR SHALL step every cycle in DRAW; in IDLE and RESP it SHALL step only when enable=1.
REQ-021 seed_load SHALL take priority over stepping in every state; seed_in==0 SHALL load SEED instead, preventing lockup.
REQ-022 FSM states: IDLE, DRAW, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-023 IDLE: on req_valid, capture req_lim, clear try counter, go to DRAW.
REQ-024 If the captured lim==0, the block SHALL go straight to RESP with rsp_data=0 and rsp_fallback=0, with no draw.
REQ-025 DRAW: candidate = lfsr_state[OUT_W-1:0] pre-step.
  - If candidate < lim: latch rsp_data=candidate and rsp_fallback=0, then go to RESP.
  - Otherwise, increment the try counter.
REQ-026 On the MAX_TRIES-th consecutive rejection: latch rsp_data=0 and rsp_fallback=1, then go to RESP.
REQ-027 RESP: rsp_data and rsp_fallback SHALL hold stable until the rsp_valid && rsp_ready cycle, then return to IDLE.
REQ-028 Minimum latency: request accepted at cycle T, rsp_valid at T+2; maximum latency is T+1+MAX_TRIES.
REQ-029 Try counter width SHALL be clog2(MAX_TRIES+1); no wrap in any state.
REQ-030 seed_load during DRAW SHALL NOT abort the draw; the next candidate comes from the loaded state.
REQ-031 When OUT_W > WIDTH, elaboration SHALL fail.

Reset
REQ-032 On rst=1, the block SHALL enter IDLE, with lfsr_state=SEED.
REQ-033 On rst=1, outputs SHALL be req_ready=1 (from next cycle), rsp_valid=0, rsp_data=0, rsp_fallback=0, try counter=0.
REQ-034 rst SHALL override seed_load, enable and any in-flight draw or pending response; the pending result is discarded.

Structure
REQ-035 Shared package rng_pkg SHALL hold:
  - default TAPS and SEED constants;
  - the FSM state enum type.
REQ-036 Stepper SHALL be one sub-module lfsr_core with ports clk, rst, step, load, load_val and state.
REQ-037 FSM, limit capture and try counter SHALL stay in lfsr_rng_range.

Verification (defaults, enable=0)
REQ-038 Step check: reset, then enable=1 for 2 cycles -> lfsr_state 0xACE1 -> 0x59C3 -> 0xB387.
REQ-039 Accept: after reset, req_lim=10 with req_valid pulse -> rsp_valid 2 cycles later, rsp_data=1, rsp_fallback=0.
REQ-040 Fallback: MAX_TRIES=3, req_lim=1 -> candidates 1, 3, 7 rejected -> rsp_data=0, rsp_fallback=1, rsp_valid at T+4.
REQ-041 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_fallback stable; req_ready=0 throughout.
REQ-042 Seed edge: seed_load with seed_in=0 -> lfsr_state=0xACE1; req_lim=0 -> rsp_data=0, rsp_fallback=0 at T+2, lfsr_state unchanged.
REQ-043 Reset mid-draw: rst asserted during DRAW -> rsp_valid never asserts, lfsr_state=0xACE1, req_ready=1 the next cycle.
